clause_pending_scheduler: RTL
=============================

Name: clause_pending_scheduler

Overview:
- Stateful successor to the combinational clause priority encoder in the BCP unit.
- Keeps a pending bitmap of CLAUSE_NUM clauses. Other blocks set bits to mark clauses for BCP evaluation.
- Scans the bitmap SEG_W bits per cycle, which keeps the encoder critical path bounded at large clause counts.
- Presents the lowest-index pending clause on a valid/ready output and clears that bit on handshake.

Parameters:
- CLAUSE_NUM, 64: number of clauses tracked; must be a multiple of SEG_W.
- CLAUSE_NUM_LOG, 6: width of the clause index; ceil(log2(CLAUSE_NUM)).
- SEG_W, 16: bits examined per scan cycle; power of two.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  clear all pending bits and abort the scan
- set_vec  in  CLAUSE_NUM  per-clause set request, ORed into pending
- out_valid  out  1  out_idx holds a pending clause
- out_ready  in  1  consumer accepts out_idx
- out_idx  out  CLAUSE_NUM_LOG  granted clause index
- pending_any  out  1  OR of the pending register
- scan_busy  out  1  FSM in SCAN

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; all state updates on the rising edge.
- Derived constant: NSEG = CLAUSE_NUM/SEG_W. seg_ptr width is ceil(log2(NSEG)), minimum 1.
- Reset: pending=0, FSM=IDLE, seg_ptr=0, out_valid=0, out_idx=0, pending_any=0, scan_busy=0.
- Pending update each cycle: pending <= (pending & ~clr) | set_vec.
  - clr is one-hot of out_idx when out_valid && out_ready, otherwise 0.
  - If set_vec sets the same bit that is cleared in that cycle, set wins and the bit stays pending.
- flush has priority over everything except rst:
  - pending <= 0; set_vec in that cycle is dropped.
  - FSM <= IDLE, seg_ptr <= 0, out_valid <= 0 on the next cycle.
  - out_idx keeps its value.
- FSM states:
  - IDLE: if pending != 0, then SCAN with seg_ptr=0.
  - SCAN: examine pending[seg_ptr*SEG_W +: SEG_W].
    - Segment non-zero: load out_idx = seg_ptr*SEG_W + lowest set bit, set out_valid=1, go to HOLD.
    - Segment zero and seg_ptr == NSEG-1: seg_ptr=0, go to IDLE.
    - Segment zero otherwise: seg_ptr++.
  - HOLD: out_valid=1 and out_idx stays stable until out_ready.
    - On handshake: out_valid=0 next cycle, seg_ptr=0, go to SCAN.
    - Zero-bubble grants are not required.
- Latency: with the FSM in IDLE and pending empty, a bit set in segment k at cycle t raises out_valid at cycle t+3+k.
- Ordering:
  - Each grant is the lowest pending index at the moment its segment was examined.
  - A bit set in an already-passed segment during a scan is picked up on a later scan.
- pending_any is the registered pending OR, combinationally reduced. It drops one cycle after the last bit is cleared.
- scan_busy = (state == SCAN).
- The FSM never holds out_valid=1 for a bit that is not pending, except when that bit is re-set in its own handshake cycle.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Without the macro: fixed priority. Every scan after a handshake restarts at segment 0.
- With the macro, the post-handshake scan is round-robin:
  - It starts at segment out_idx/SEG_W, masking bits <= out_idx on that first visit.
  - It then proceeds through the remaining segments with wrap-around, all unmasked.
  - It finally revisits the start segment unmasked: NSEG+1 examinations worst case before IDLE.
  - Scans entered from IDLE still start at segment 0, unmasked.
- This fairness prevents starvation of high clause indices.

Test Plan:
- Reset: assert rst 2 cycles with set_vec=all ones -> out_valid=0, out_idx=0, pending_any=0, scan_busy=0 after release; pending stays 0 because rst overrides set.
- Single clause: set_vec[5] pulsed at cycle t, out_ready=1 -> out_valid at t+3 with out_idx=5; handshake at t+3; pending_any=0 at t+4.
- Two segments: set_vec bits 3 and 40 together, out_ready=1 -> grant 3; after handshake at cycle h, grant 40 with out_valid at h+4 (segments 0, 1, 2 scanned).
- Back-pressure and collision:
  - Hold bit 20 with out_ready=0 for 10 cycles and set bit 1 during the hold -> out_idx stays 20; after accept, 1 is granted next.
  - Re-setting bit 20 in its handshake cycle -> 20 is granted again later.
- Flush mid-scan: pending {50}, assert flush while scan_busy=1 with set_vec[7]=1 -> out_valid stays 0, pending_any=0 next cycle, and 7 is never granted.
- ROUND_ROBIN_EN: pending {2, 10}; grant 2; set bit 1 before the next grant -> order is 2, 10, 1. Without the macro the order is 2, 1, 10.

Source files
------------

// File: rtl/clause_pending_scheduler.sv
// clause_pending_scheduler
// Pending-clause bitmap with a segmented scan. Other blocks OR set requests
// into the bitmap. The FSM examines SEG_W bits per cycle and offers the
// lowest pending index on a valid/ready port. The offered bit is cleared when
// the consumer accepts it.
// Optional build macro ROUND_ROBIN_EN: a scan that follows a handshake resumes
// just after the last grant instead of at segment 0.
module clause_pending_scheduler #(
  parameter int CLAUSE_NUM     = 64,
  parameter int CLAUSE_NUM_LOG = 6,
  parameter int SEG_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [CLAUSE_NUM-1:0]     set_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CLAUSE_NUM_LOG-1:0] out_idx,
  output logic                      pending_any,
  output logic                      scan_busy
);

  localparam int NSEG  = CLAUSE_NUM / SEG_W;
  localparam int PTR_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int LO_W  = (SEG_W > 1) ? $clog2(SEG_W) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]                      state;
  logic [PTR_W-1:0]                seg_ptr;
  logic [PTR_W-1:0]                next_ptr;
  logic [PTR_W-1:0]                restart_ptr;
  logic [CLAUSE_NUM-1:0]           pending;
  logic [CLAUSE_NUM-1:0]           clr_vec;
  logic [NSEG-1:0][SEG_W-1:0]      pending_seg;
  logic [SEG_W-1:0]                seg_mask;
  logic [SEG_W-1:0]                seg_eff;
  logic                            seg_hit;
  logic [LO_W-1:0]                 low_bit;
  logic [LO_W-1:0]                 mask_lo;
  logic [CLAUSE_NUM_LOG-1:0]       hit_idx;
  logic                            handshake;
  logic                            first_visit;
  logic                            last_exam;

  assign handshake   = out_valid && out_ready;
  assign pending_seg = pending;
  assign pending_any = |pending;
  assign scan_busy   = (state == ST_SCAN);
  assign next_ptr    = (seg_ptr == PTR_W'(NSEG - 1)) ? '0 : seg_ptr + 1'b1;

`ifdef ROUND_ROBIN_EN
  localparam int CNT_W = $clog2(NSEG + 1);

  logic             rr_scan;
  logic [CNT_W-1:0] scan_cnt;

  // out_idx is frozen for the whole scan, so the resume point and the
  // first-visit mask can be derived from it directly.
  assign restart_ptr = PTR_W'(out_idx / SEG_W);
  assign mask_lo     = LO_W'(out_idx % SEG_W);
  assign first_visit = rr_scan && (scan_cnt == '0);
  // A resumed scan revisits its start segment unmasked: one extra examination.
  assign last_exam   = rr_scan ? (scan_cnt == CNT_W'(NSEG))
                               : (scan_cnt == CNT_W'(NSEG - 1));

  // Track scan origin and the number of segments examined so far.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_scan  <= 1'b0;
      scan_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rr_scan  <= 1'b0;
          scan_cnt <= '0;
        end
        ST_SCAN: begin
          if (!seg_hit) scan_cnt <= scan_cnt + 1'b1;
        end
        ST_HOLD: begin
          if (out_ready) begin
            rr_scan  <= 1'b1;
            scan_cnt <= '0;
          end
        end
        default: begin
          rr_scan  <= 1'b0;
          scan_cnt <= '0;
        end
      endcase
    end
  end
`else
  assign restart_ptr = '0;
  assign mask_lo     = '0;
  assign first_visit = 1'b0;
  assign last_exam   = (seg_ptr == PTR_W'(NSEG - 1));
`endif

  // One-hot clear of the clause being accepted this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    clr_vec = '0;
    if (handshake) clr_vec[out_idx] = 1'b1;
  end

  // Mask off indices at or below the last grant on a resumed scan's first visit.
  always_comb begin
    seg_mask = '1;
    for (int j = 0; j < SEG_W; j++) begin
      seg_mask[j] = !first_visit || (LO_W'(j) > mask_lo);
    end
  end

  // Lowest set bit in the segment under examination.
  always_comb begin
    seg_eff = pending_seg[seg_ptr] & seg_mask;
    seg_hit = |seg_eff;
    low_bit = '0;
    for (int j = SEG_W - 1; j >= 0; j--) begin
      if (seg_eff[j]) low_bit = LO_W'(j);
    end
    hit_idx = CLAUSE_NUM_LOG'(seg_ptr) * CLAUSE_NUM_LOG'(SEG_W)
            + CLAUSE_NUM_LOG'(low_bit);
  end

  // Pending bitmap update and IDLE/SCAN/HOLD sequencing.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      pending   <= '0;
      state     <= ST_IDLE;
      seg_ptr   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (flush) begin
      // out_idx deliberately keeps its last value.
      pending   <= '0;
      state     <= ST_IDLE;
      seg_ptr   <= '0;
      out_valid <= 1'b0;
    end else begin
      // Set is ORed after the clear, so a re-set in the handshake cycle wins.
      pending <= (pending & ~clr_vec) | set_vec;
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            state   <= ST_SCAN;
            seg_ptr <= '0;
          end
        end
        ST_SCAN: begin
          if (seg_hit) begin
            out_idx   <= hit_idx;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end else if (last_exam) begin
            seg_ptr <= '0;
            state   <= ST_IDLE;
          end else begin
            seg_ptr <= next_ptr;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            seg_ptr   <= restart_ptr;
            state     <= ST_SCAN;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
